// File: rtl/core_pkg.sv
// Shared constants for the second-generation core datapath: ALU opcodes,
// bus source select codes and the memory-port FSM state encoding.
package core_pkg;

    // ALU operation codes (in1 = AC, in2 = bus)
    localparam logic [2:0] ALU_PASS = 3'd0;  // result = in2
    localparam logic [2:0] ALU_ADD  = 3'd1;  // in1 + in2
    localparam logic [2:0] ALU_SUB  = 3'd2;  // in1 - in2
    localparam logic [2:0] ALU_MUL  = 3'd3;  // low DATA_W bits of in1 * in2
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;
    localparam logic [2:0] ALU_XOR  = 3'd6;
    localparam logic [2:0] ALU_SHR  = 3'd7;  // in1 >> 1, logical

    // Bus source select codes; GPR i sits at SEL_GPR_BASE + i
    localparam int SEL_PC       = 0;
    localparam int SEL_DR       = 1;
    localparam int SEL_AC       = 2;
    localparam int SEL_MDR      = 3;
    localparam int SEL_CORE_ID  = 4;
    localparam int SEL_IR       = 5;
    localparam int SEL_ZERO0    = 6;
    localparam int SEL_ZERO1    = 7;
    localparam int SEL_GPR_BASE = 8;

    // Memory-port FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Width of the bus select field for a given GPR count
    function automatic int sel_width(input int gpr_cnt);
        return $clog2(SEL_GPR_BASE + gpr_cnt);
    endfunction

endpackage

// File: rtl/core_alu_p.sv
// Combinational 8-mode ALU. in1 is the accumulator, in2 is the bus; every
// result wraps to DATA_W bits.
module core_alu_p
    import core_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [2:0]        mode,
    output logic [DATA_W-1:0] result
);

    // Operation select; the assignment context truncates ADD/SUB/MUL to DATA_W
    always_comb begin
        result = '0;
        case (mode)
            ALU_PASS: result = in2;
            ALU_ADD:  result = in1 + in2;
            ALU_SUB:  result = in1 - in2;
            ALU_MUL:  result = in1 * in2;
            ALU_AND:  result = in1 & in2;
            ALU_OR:   result = in1 | in2;
            ALU_XOR:  result = in1 ^ in2;
            ALU_SHR:  result = in1 >> 1;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/core_datapath_p.sv
// Parametrised processing-core datapath: register file, bus multiplexer,
// accumulator/ALU and a two-state memory-port FSM that stalls the external
// control-word sequencer while a memory transaction is in flight.
//
// Memory handshake: a transaction is launched from IDLE by mem_rd or mem_wr;
// the address, write data, space and direction are latched and held stable
// for the whole transaction. mem_req is high in every BUSY cycle; the
// transaction completes in the first BUSY cycle where mem_ready is also high
// (read data is taken from mem_rdata in that cycle). mem_ready outside BUSY
// carries no meaning and is ignored.
module core_datapath_p
    import core_pkg::*;
#(
    parameter  int DATA_W    = 16,
    parameter  int ADDR_W    = 16,
    parameter  int GPR_CNT   = 8,
    parameter  int CORE_ID_W = 5,
    localparam int SEL_W     = sel_width(GPR_CNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CORE_ID_W-1:0] core_id,
    input  logic [SEL_W-1:0]     bus_sel,
    input  logic [GPR_CNT-1:0]   rf_we,
    input  logic                 pc_we,
    input  logic                 pc_inc,
    input  logic                 pc_clr,
    input  logic                 ar_we,
    input  logic                 ar_src,
    input  logic                 dr_we,
    input  logic                 ir_we,
    input  logic                 ac_we,
    input  logic                 ac_inc,
    input  logic                 ac_clr,
    input  logic [2:0]           alu_mode,
    input  logic                 mem_rd,
    input  logic                 mem_wr,
    input  logic                 mem_space,
    output logic [DATA_W-1:0]    ir_out,
    output logic                 z,
    output logic                 stall,
    output logic                 err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_dm,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_ready
);

    // Architectural registers
    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [ADDR_W-1:0] ar_q,  ar_d;
    logic [DATA_W-1:0] dr_q,  dr_d;
    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] ac_q,  ac_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] gpr_q [GPR_CNT];
    logic [DATA_W-1:0] gpr_d [GPR_CNT];

    // Memory-port FSM and latched request
    logic [0:0]        state_q,     state_d;
    logic              mem_we_q,    mem_we_d;
    logic              mem_dm_q,    mem_dm_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_q,       err_d;

    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] alu_res;
    logic              busy;
    logic              exec;
    int                sel_i;

    assign busy = (state_q == ST_BUSY);
    // The control word only takes effect while no transaction is in flight
    assign exec = ~busy;

    core_alu_p #(
        .DATA_W (DATA_W)
    ) u_alu (
        .in1    (ac_q),
        .in2    (bus),
        .mode   (alu_mode),
        .result (alu_res)
    );

    // Bus source multiplexer; unused codes and codes past the last GPR drive 0
    always_comb begin
        bus   = '0;
        sel_i = int'(bus_sel);
        case (sel_i)
            SEL_PC:      bus = DATA_W'(pc_q);
            SEL_DR:      bus = dr_q;
            SEL_AC:      bus = ac_q;
            SEL_MDR:     bus = mdr_q;
            SEL_CORE_ID: bus = DATA_W'(core_id);
            SEL_IR:      bus = ir_q;
            SEL_ZERO0:   bus = '0;
            SEL_ZERO1:   bus = '0;
            default: begin
                for (int i = 0; i < GPR_CNT; i++) begin
                    if (sel_i == SEL_GPR_BASE + i) begin
                        bus = gpr_q[i];
                    end
                end
            end
        endcase
    end

    // Next-state for PC, AR, DR, IR, AC and GPRs; all frozen while busy
    always_comb begin
        pc_d = pc_q;
        ar_d = ar_q;
        dr_d = dr_q;
        ir_d = ir_q;
        ac_d = ac_q;
        for (int i = 0; i < GPR_CNT; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        if (exec) begin
            // PC: clear beats load beats increment; increment wraps naturally
            if (pc_clr) begin
                pc_d = '0;
            end else if (pc_we) begin
                pc_d = ADDR_W'(bus);
            end else if (pc_inc) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            if (ar_we) begin
                ar_d = ar_src ? ADDR_W'(bus) : pc_q;
            end
            if (dr_we) begin
                dr_d = bus;
            end
            if (ir_we) begin
                ir_d = bus;
            end
            // AC: clear beats ALU load beats increment
            if (ac_clr) begin
                ac_d = '0;
            end else if (ac_we) begin
                ac_d = alu_res;
            end else if (ac_inc) begin
                ac_d = ac_q + DATA_W'(1);
            end
            for (int i = 0; i < GPR_CNT; i++) begin
                if (rf_we[i]) begin
                    gpr_d[i] = bus;
                end
            end
        end
    end

    // Memory FSM: launch from IDLE, wait in BUSY for mem_ready, capture reads
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_dm_d    = mem_dm_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        mdr_d       = mdr_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_rd || mem_wr) begin
                    // The current AR (not this cycle's AR update) is the address
                    mem_addr_d  = ar_q;
                    mem_wdata_d = bus;
                    mem_dm_d    = mem_space;
                    // A simultaneous read and write resolves as a write
                    mem_we_d    = mem_wr;
                    if (mem_rd && mem_wr) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        mdr_d = mem_rdata;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register update with synchronous reset; reset also aborts any transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            ar_q        <= '0;
            dr_q        <= '0;
            ir_q        <= '0;
            ac_q        <= '0;
            mdr_q       <= '0;
            for (int i = 0; i < GPR_CNT; i++) begin
                gpr_q[i] <= '0;
            end
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_dm_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ar_q        <= ar_d;
            dr_q        <= dr_d;
            ir_q        <= ir_d;
            ac_q        <= ac_d;
            mdr_q       <= mdr_d;
            for (int i = 0; i < GPR_CNT; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_dm_q    <= mem_dm_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    assign ir_out    = ir_q;
    assign z         = (ac_q == '0);
    assign stall     = busy;
    assign mem_req   = busy;
    assign err       = err_q;
    assign mem_we    = mem_we_q;
    assign mem_dm    = mem_dm_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_core_datapath_p.sv
// Directed bench for core_datapath_p: expected values are queued as stimulus
// is driven and popped as the corresponding DUT output is sampled.
module tb_core_datapath_p;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int GPR_CNT   = 8;
    localparam int CORE_ID_W = 5;
    localparam int SEL_W     = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [CORE_ID_W-1:0] core_id;
    logic [SEL_W-1:0]     bus_sel;
    logic [GPR_CNT-1:0]   rf_we;
    logic                 pc_we, pc_inc, pc_clr;
    logic                 ar_we, ar_src;
    logic                 dr_we, ir_we;
    logic                 ac_we, ac_inc, ac_clr;
    logic [2:0]           alu_mode;
    logic                 mem_rd, mem_wr, mem_space;
    logic [DATA_W-1:0]    ir_out;
    logic                 z, stall, err;
    logic                 mem_req, mem_we, mem_dm;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;
    logic                 mem_ready;

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Clock
    always #5 clk = ~clk;

    core_datapath_p #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .GPR_CNT   (GPR_CNT),
        .CORE_ID_W (CORE_ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .core_id   (core_id),
        .bus_sel   (bus_sel),
        .rf_we     (rf_we),
        .pc_we     (pc_we),
        .pc_inc    (pc_inc),
        .pc_clr    (pc_clr),
        .ar_we     (ar_we),
        .ar_src    (ar_src),
        .dr_we     (dr_we),
        .ir_we     (ir_we),
        .ac_we     (ac_we),
        .ac_inc    (ac_inc),
        .ac_clr    (ac_clr),
        .alu_mode  (alu_mode),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_space (mem_space),
        .ir_out    (ir_out),
        .z         (z),
        .stall     (stall),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_dm    (mem_dm),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // Reference ALU
    function automatic logic [15:0] alu_ref(input int m, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] w;
        case (m)
            0: w = {16'h0, b};
            1: w = {16'h0, a} + {16'h0, b};
            2: w = {16'h0, a} - {16'h0, b};
            3: w = {16'h0, a} * {16'h0, b};
            4: w = {16'h0, a & b};
            5: w = {16'h0, a | b};
            6: w = {16'h0, a ^ b};
            default: w = {17'h0, a[15:1]};
        endcase
        return w[15:0];
    endfunction

    // Scoreboard compare: pop the oldest expected value
    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h with no expected value queued", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        bus_sel = '0; rf_we = '0;
        pc_we = 0; pc_inc = 0; pc_clr = 0;
        ar_we = 0; ar_src = 0; dr_we = 0; ir_we = 0;
        ac_we = 0; ac_inc = 0; ac_clr = 0; alu_mode = 3'd0;
        mem_rd = 0; mem_wr = 0; mem_space = 0;
    endtask

    // Copy a bus source into IR so it becomes observable on ir_out
    task automatic read_bus(input int sel);
        bus_sel = 4'(sel);
        ir_we = 1;
        tick();
        ir_we = 0;
    endtask

    // AC <= ALU(AC, zero-extended core_id)
    task automatic alu_op(input int m, input int cid);
        bus_sel = 4'(4);
        core_id = 5'(cid);
        alu_mode = 3'(m);
        ac_we = 1;
        tick();
        ac_we = 0;
    endtask

    initial begin
        // Reset
        clear_ctrl();
        core_id = '0;
        mem_rdata = '0;
        mem_ready = 0;
        rst = 1;
        tick();
        tick();
        exp_q.push_back(32'h0);  check("rst_ir_out", ir_out);
        exp_q.push_back(32'h1);  check("rst_z", z);
        exp_q.push_back(32'h0);  check("rst_stall", stall);
        exp_q.push_back(32'h0);  check("rst_err", err);
        exp_q.push_back(32'h0);  check("rst_mem_req", mem_req);
        exp_q.push_back(32'h0);  check("rst_mem_we", mem_we);
        exp_q.push_back(32'h0);  check("rst_mem_dm", mem_dm);
        exp_q.push_back(32'h0);  check("rst_mem_addr", mem_addr);
        exp_q.push_back(32'h0);  check("rst_mem_wdata", mem_wdata);
        rst = 0;

        // core_id onto bus, into GPR2, read back through sel 10
        core_id = 5'd19;
        exp_q.push_back(32'h0013);
        read_bus(4);
        check("core_id_bus", ir_out);
        bus_sel = 4'd4; rf_we = 8'b100;
        tick();
        rf_we = '0;
        exp_q.push_back(32'h0013);
        read_bus(10);
        check("gpr2_load", ir_out);

        // ADD wrap and MUL to zero
        alu_op(2, 1);                       // 0 - 1 = FFFF
        exp_q.push_back(32'hFFFF);
        read_bus(2);
        check("ac_ffff", ir_out);
        alu_op(1, 2);
        exp_q.push_back(32'h0001);
        exp_q.push_back(32'h0);
        read_bus(2);
        check("add_wrap", ir_out);
        check("add_wrap_z", z);
        alu_op(0, 16);
        alu_op(3, 16);                      // AC = 0x0100
        bus_sel = 4'd2; rf_we = 8'b1;       // GPR0 = 0x0100
        tick();
        rf_we = '0;
        bus_sel = 4'd8; alu_mode = 3'd3; ac_we = 1;
        tick();
        ac_we = 0;
        exp_q.push_back(32'h0000);
        exp_q.push_back(32'h1);
        read_bus(2);
        check("mul_wrap", ir_out);
        check("mul_wrap_z", z);

        // Build 0x1234 in AC and keep a copy in GPR1
        alu_op(0, 18);
        alu_op(3, 16);
        alu_op(3, 16);
        alu_op(1, 31);
        alu_op(1, 21);
        bus_sel = 4'd2; rf_we = 8'b10;
        tick();
        rf_we = '0;

        // Every ALU mode against AC=0x1234, bus=0x001B
        for (int m = 0; m < 8; m++) begin
            bus_sel = 4'd9; alu_mode = 3'd0; ac_we = 1;
            tick();
            ac_we = 0;
            alu_op(m, 27);
            exp_q.push_back({16'h0, alu_ref(m, 16'h1234, 16'h001B)});
            read_bus(2);
            check($sformatf("alu_mode%0d", m), ir_out);
        end

        // AC priority: clr > we > inc
        alu_op(0, 9);
        ac_clr = 1; ac_we = 1; bus_sel = 4'd4; core_id = 5'd5;
        tick();
        ac_clr = 0; ac_we = 0;
        exp_q.push_back(32'h0);
        read_bus(2);
        check("ac_clr_prio", ir_out);
        ac_we = 1; ac_inc = 1; alu_mode = 3'd0; bus_sel = 4'd4; core_id = 5'd5;
        tick();
        ac_we = 0; ac_inc = 0;
        exp_q.push_back(32'h5);
        read_bus(2);
        check("ac_we_prio", ir_out);
        ac_inc = 1;
        tick();
        ac_inc = 0;
        exp_q.push_back(32'h6);
        read_bus(2);
        check("ac_inc", ir_out);

        // Read from data memory at AR=0x0040 with three BUSY cycles
        alu_op(0, 16);
        alu_op(3, 4);                       // AC = 0x0040
        bus_sel = 4'd2; ar_we = 1; ar_src = 1;
        tick();
        ar_we = 0; ar_src = 0;
        mem_rd = 1; mem_space = 1;
        tick();
        // Hold the control word plus extra writes; all must be suppressed
        rf_we = 8'b1000; bus_sel = 4'd4; core_id = 5'd7; ac_inc = 1; pc_inc = 1;
        exp_q.push_back(32'h1);      check("rd_req_c1", mem_req);
        exp_q.push_back(32'h1);      check("rd_stall_c1", stall);
        exp_q.push_back(32'h0040);   check("rd_addr", mem_addr);
        exp_q.push_back(32'h1);      check("rd_dm", mem_dm);
        exp_q.push_back(32'h0);      check("rd_we", mem_we);
        tick();
        exp_q.push_back(32'h1);      check("rd_req_c2", mem_req);
        tick();
        exp_q.push_back(32'h1);      check("rd_req_c3", mem_req);
        mem_ready = 1; mem_rdata = 16'hBEEF;
        tick();
        mem_ready = 0; mem_rdata = '0;
        clear_ctrl();
        exp_q.push_back(32'h0);      check("rd_req_done", mem_req);
        exp_q.push_back(32'h0);      check("rd_stall_done", stall);
        exp_q.push_back(32'hBEEF);
        read_bus(3);
        check("rd_mdr", ir_out);
        exp_q.push_back(32'h0);
        read_bus(11);
        check("stall_gpr3", ir_out);
        exp_q.push_back(32'h0040);
        read_bus(2);
        check("stall_ac", ir_out);
        exp_q.push_back(32'h0);
        read_bus(0);
        check("stall_pc", ir_out);

        // mem_ready in IDLE is ignored
        mem_ready = 1; mem_rdata = 16'h5555;
        tick();
        mem_ready = 0;
        exp_q.push_back(32'h0);      check("idle_ready_stall", stall);
        exp_q.push_back(32'hBEEF);
        read_bus(3);
        check("idle_ready_mdr", ir_out);

        // Write with mem_ready already high; AR reload in the same cycle not used
        bus_sel = 4'd9; mem_wr = 1; mem_space = 0; mem_ready = 1;
        ar_we = 1; ar_src = 0;
        tick();
        mem_wr = 0; ar_we = 0;
        exp_q.push_back(32'h1);      check("wr_stall", stall);
        exp_q.push_back(32'h1);      check("wr_we", mem_we);
        exp_q.push_back(32'h1234);   check("wr_wdata", mem_wdata);
        exp_q.push_back(32'h0040);   check("wr_addr_old_ar", mem_addr);
        exp_q.push_back(32'h0);      check("wr_dm", mem_dm);
        tick();
        mem_ready = 0;
        exp_q.push_back(32'h0);      check("wr_req_done", mem_req);
        exp_q.push_back(32'h0);      check("wr_err", err);
        exp_q.push_back(32'hBEEF);
        read_bus(3);
        check("wr_mdr_kept", ir_out);

        // Read and write together: write wins, err sticky
        bus_sel = 4'd4; core_id = 5'd9; mem_rd = 1; mem_wr = 1;
        tick();
        mem_rd = 0; mem_wr = 0;
        exp_q.push_back(32'h1);      check("both_we", mem_we);
        exp_q.push_back(32'h0009);   check("both_wdata", mem_wdata);
        exp_q.push_back(32'h1);      check("both_err", err);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        exp_q.push_back(32'h0);      check("both_done_stall", stall);
        mem_rd = 1;
        tick();
        mem_rd = 0;
        mem_ready = 1; mem_rdata = 16'h0777;
        tick();
        mem_ready = 0;
        exp_q.push_back(32'h1);      check("err_sticky", err);
        exp_q.push_back(32'h0777);
        read_bus(3);
        check("rd2_mdr", ir_out);

        // Reset mid-BUSY, then a stray mem_ready
        mem_rd = 1;
        tick();
        mem_rd = 0;
        exp_q.push_back(32'h1);      check("abort_busy", stall);
        rst = 1;
        tick();
        rst = 0;
        exp_q.push_back(32'h0);      check("abort_stall", stall);
        exp_q.push_back(32'h0);      check("abort_req", mem_req);
        exp_q.push_back(32'h0);      check("abort_err", err);
        mem_ready = 1; mem_rdata = 16'hAAAA;
        tick();
        mem_ready = 0;
        exp_q.push_back(32'h0);      check("abort_ready_req", mem_req);
        exp_q.push_back(32'h0);
        read_bus(3);
        check("abort_mdr", ir_out);

        // PC priority: we beats inc, clr beats we
        bus_sel = 4'd4; core_id = 5'd21; pc_we = 1; pc_inc = 1;
        tick();
        pc_we = 0; pc_inc = 0;
        exp_q.push_back(32'd21);
        read_bus(0);
        check("pc_we_prio", ir_out);
        pc_inc = 1;
        tick();
        pc_inc = 0;
        exp_q.push_back(32'd22);
        read_bus(0);
        check("pc_inc", ir_out);
        exp_q.push_back(32'h0);
        read_bus(6);
        check("sel6_zero", ir_out);
        read_bus(0);
        exp_q.push_back(32'h0);
        read_bus(7);
        check("sel7_zero", ir_out);
        bus_sel = 4'd4; pc_clr = 1; pc_we = 1;
        tick();
        pc_clr = 0; pc_we = 0;
        exp_q.push_back(32'h0);
        read_bus(0);
        check("pc_clr_prio", ir_out);

        // Every queued expectation must have been consumed
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
